// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
//   ADDR_W    default PC / instruction-memory byte-address width
//   RESET_PC  default first fetch address after reset
//   PC_INC    byte stride between sequential 16-bit instructions
//   INSTR_W   instruction width
//   NOP       encoding loaded into an empty IF/ID register
package fetch_unit_pkg;
    localparam int ADDR_W = 16;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;
    localparam int PC_INC = 2;
    localparam int INSTR_W = 16;
    localparam logic [INSTR_W-1:0] NOP = 16'h0000;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_WAIT
    } fetch_state_e;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched instruction that decode could
// not accept (IF/ID stalled when the response arrived).
//   clk, rst_n            clock, async active-low reset
//   push, push_instr/pc   capture a response (replaces any held entry)
//   pop                   entry consumed by IF/ID
//   clear                 drop the entry (redirect)
//   instr, pc, full       held entry and its occupancy
module fetch_skid_buf #(
    parameter int ADDR_W = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push,
    input  logic                             pop,
    input  logic                             clear,
    input  logic [fetch_unit_pkg::INSTR_W-1:0] push_instr,
    input  logic [ADDR_W-1:0]                push_pc,
    output logic [fetch_unit_pkg::INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]                pc,
    output logic                             full
);
    import fetch_unit_pkg::*;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full  <= 1'b0;
            instr <= NOP;
            pc    <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (push) begin
            full  <= 1'b1;
            instr <= push_instr;
            pc    <= push_pc;
        end else if (pop) begin
            full <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage plus IF/ID pipeline register. Keeps at most one
// request outstanding, honours hazard-unit stalls and flushes on redirect.
//   clk, rst_n             clock, async active-low reset
//   PCWrite, IFWrite       hazard-unit stall controls (0 = hold)
//   br_taken, br_target    one-cycle redirect from branch resolution
//   imem_req, imem_addr    fetch request (combinational)
//   imem_valid, imem_rdata fetch response
//   ifid_instr/pc/valid    IF/ID register towards decode
//
//   state      | meaning
//   FETCH_IDLE | first cycle after reset release, nothing issued
//   FETCH_REQ  | no request outstanding; issue when allowed
//   FETCH_WAIT | one request outstanding, waiting for imem_valid
module fetch_unit #(
    parameter int ADDR_W = fetch_unit_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = fetch_unit_pkg::RESET_PC
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               PCWrite,
    input  logic                               IFWrite,
    input  logic                               br_taken,
    input  logic [ADDR_W-1:0]                  br_target,
    output logic                               imem_req,
    output logic [ADDR_W-1:0]                  imem_addr,
    input  logic                               imem_valid,
    input  logic [fetch_unit_pkg::INSTR_W-1:0] imem_rdata,
    output logic [fetch_unit_pkg::INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]                  ifid_pc,
    output logic                               ifid_valid
);
    import fetch_unit_pkg::*;

    fetch_state_e      state, state_next;
    logic [ADDR_W-1:0] pc, pc_next, fetch_pc;
    logic              discard, discard_next;
    logic              resp_use, skid_push, skid_pop, skid_full_after;
    logic              can_issue, issue;
    logic [INSTR_W-1:0] skid_instr;
    logic [ADDR_W-1:0] skid_pc;
    logic              skid_full;

    fetch_skid_buf #(.ADDR_W(ADDR_W)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (skid_push),
        .pop        (skid_pop),
        .clear      (br_taken),
        .push_instr (imem_rdata),
        .push_pc    (fetch_pc),
        .instr      (skid_instr),
        .pc         (skid_pc),
        .full       (skid_full)
    );

    // A response is only consumed in WAIT, when it is not stale and not
    // overtaken by a redirect in the same cycle.
    always_comb begin
        resp_use        = (state == FETCH_WAIT) && imem_valid && !discard && !br_taken;
        skid_push       = resp_use && (!IFWrite || skid_full);
        skid_pop        = !br_taken && IFWrite && skid_full;
        skid_full_after = !br_taken && (skid_push || (skid_full && !skid_pop));
        can_issue       = PCWrite && !br_taken && !skid_full_after;
        issue           = can_issue && ((state == FETCH_REQ) || resp_use);
    end

    assign imem_req  = issue;
    assign imem_addr = pc;

    always_comb begin
        state_next   = state;
        discard_next = discard;
        pc_next      = pc;
        if (br_taken) begin
            pc_next = br_target;
        end else if (issue) begin
            pc_next = pc + ADDR_W'(PC_INC);
        end
        case (state)
            FETCH_IDLE: state_next = FETCH_REQ;
            FETCH_REQ:  if (issue) state_next = FETCH_WAIT;
            FETCH_WAIT: begin
                if (imem_valid) begin
                    discard_next = 1'b0;
                    state_next   = issue ? FETCH_WAIT : FETCH_REQ;
                end else if (br_taken) begin
                    // stay until the abandoned response comes back
                    discard_next = 1'b1;
                end
            end
            default: state_next = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH_IDLE;
            pc       <= RESET_PC;
            fetch_pc <= RESET_PC;
            discard  <= 1'b0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            discard <= discard_next;
            if (issue) fetch_pc <= pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP;
            ifid_pc    <= '0;
        end else if (br_taken) begin
            ifid_valid <= 1'b0;
        end else if (IFWrite) begin
            if (skid_full) begin
                ifid_valid <= 1'b1;
                ifid_instr <= skid_instr;
                ifid_pc    <= skid_pc;
            end else if (resp_use) begin
                ifid_valid <= 1'b1;
                ifid_instr <= imem_rdata;
                ifid_pc    <= fetch_pc;
            end else begin
                ifid_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage and IF/ID pipeline register of the 16-bit pipelined core. Holds the PC and issues one-outstanding requests to instruction memory. It presents fetched instructions to decode and obeys the `PCWrite`/`IFWrite` stall outputs of the hazard detection circuit. Branch redirects from the resolve stage flush the IF/ID register and any in-flight fetch.

## Interface
- `ADDR_W`, 16, PC / instruction-memory byte-address width
- `RESET_PC`, 16'h0000, first fetch address after reset
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `PCWrite`  in  1  from hazard unit; 0 = no new fetch issue, PC holds
- `IFWrite`  in  1  from hazard unit; 0 = IF/ID register holds
- `br_taken`  in  1  single-cycle redirect pulse from branch resolution
- `br_target`  in  ADDR_W  redirect address, valid with `br_taken`
- `imem_req`  out  1  fetch request, accepted unconditionally in the cycle asserted
- `imem_addr`  out  ADDR_W  fetch address, valid with `imem_req`
- `imem_valid`  in  1  response strobe, ≥1 cycle after request
- `imem_rdata`  in  16  instruction, valid with `imem_valid`
- `ifid_instr`  out  16  IF/ID instruction (drives decode / hazard-unit opcode inputs)
- `ifid_pc`  out  ADDR_W  address of `ifid_instr`
- `ifid_valid`  out  1  IF/ID holds a real instruction

## Operation
- Registers:
  - `pc`: next fetch address.
  - `fetch_pc`: address of the outstanding request.
  - `state` ∈ {IDLE, REQ, WAIT}.
  - `discard` flag.
  - 1-entry skid buffer (instr, pc, full).
  - IF/ID register.
- Reset values:
  - `pc`=`RESET_PC`, `state`=IDLE, `discard`=0, skid empty.
  - `ifid_valid`=0, `ifid_instr`=16'h0000, `ifid_pc`=0.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
- Issue condition `can_issue` = `PCWrite` & !`br_taken` & skid empty after this cycle.
  - On issue: `imem_req`=1, `imem_addr`=`pc`, `fetch_pc`←`pc`, `pc`←`pc`+2 (mod 2^ADDR_W, wraps silently).
- IDLE → REQ unconditionally on the first edge after reset release.
- REQ:
  - `can_issue` → WAIT.
  - Otherwise stay in REQ with `imem_req`=0.
- WAIT, no `imem_valid`: stay in WAIT.
- WAIT, `imem_valid` with `discard`=1: drop the response, clear `discard`, go to REQ.
- WAIT, `imem_valid` with `discard`=0:
  - If `IFWrite`=1 and skid empty: IF/ID ← {rdata, `fetch_pc`, valid=1}.
  - If `IFWrite`=0: response goes to the skid buffer.
  - Then issue in the same cycle if `can_issue` (stay in WAIT); else go to REQ.
- IF/ID update when `IFWrite`=1 (no response being consumed):
  - Skid full: load IF/ID from skid and clear skid.
  - Skid empty: `ifid_valid`←0 (bubble).
- `IFWrite`=0: IF/ID holds all fields.
- Redirect `br_taken`=1 has highest priority, overriding both `PCWrite` and `IFWrite`:
  - `pc`←`br_target`, `ifid_valid`←0, skid cleared, no issue this cycle, next state REQ.
  - If in WAIT with no `imem_valid` this cycle: `discard`←1, and state stays WAIT until the stale response returns.
  - A response arriving in the redirect cycle is dropped.
- Redirect while `discard`=1: `discard` stays 1 and `pc` takes the newest target.
- Never more than one outstanding request; `imem_valid` outside WAIT is ignored.

## Timing
- `imem_req`/`imem_addr` are combinational from state, `pc`, `PCWrite`, `br_taken`, `imem_valid`, `IFWrite`. All other outputs are registered.
- Reset release at edge 0:
  - Edge 1: enter REQ.
  - Cycle after edge 1: `imem_req`=1, addr=`RESET_PC`.
  - With 1-cycle memory, `ifid_valid`=1 after edge 3.
- Throughput with 1-cycle memory and no stalls: one instruction per cycle.
- Stall: `PCWrite`=`IFWrite`=0 for N cycles freezes IF/ID for N cycles. At most one instruction lands in the skid; none is lost or duplicated.
- Redirect penalty:
  - `ifid_valid`=0 the edge after `br_taken`.
  - Target instruction reaches IF/ID 2 edges after redirect with 1-cycle memory; +1 if a stale response must be discarded.
- Asynchronous reset mid-fetch: all state returns to reset values immediately, and any later `imem_valid` from the abandoned request is ignored (IDLE/REQ).

## Structure
- Shared core package holds:
  - `ADDR_W`, `RESET_PC`.
  - `PC_INC`=2.
  - `INSTR_W`=16.
  - NOP encoding 16'h0000.
  - fetch state enum.
- Sub-module `fetch_skid_buf`: 1-entry {instr, pc} holding register with push/pop/clear and `full`. The rest stays in `fetch_unit`.

## Test plan
- Reset, then 1-cycle memory returning `16'h2001`, `16'h2102`, … at 0x0000, 0x0002, … → `ifid_pc` 0x0000, 0x0002, 0x0004 on consecutive cycles with `ifid_valid`=1.
- `PCWrite`=`IFWrite`=0 for 3 cycles while a response is in flight → IF/ID frozen 3 cycles, skid captures the response, no `imem_req`. On release, sequence resumes with no gap or duplicate.
- `br_taken` with target 0x0040 while WAIT on 0x0006 with 3-cycle latency → stale 0x0006 data dropped, `ifid_valid`=0, next valid `ifid_pc`=0x0040.
- `br_taken` in the same cycle as `imem_valid` and `IFWrite`=0 → response dropped, skid cleared, IF/ID flushed, next fetch addr = target.
- PC wrap: `RESET_PC`=16'hFFFE → fetches 0xFFFE then 0x0000.
- `rst_n` asserted mid-WAIT, late `imem_valid` pulse after release → ignored; first `ifid_pc`=`RESET_PC`.
